// File: rtl/tlb_mp_if.sv
// Lookup-port bundle for the multi-port TLB.
// The requester drives VA/ASID; the TLB returns registered results.
interface tlb_mp_if #(
  parameter int NUM    = 16,
  parameter int NPORT  = 2,
  parameter int ASID_W = 10,
  parameter int PALEN  = 32
);
  localparam int IW    = $clog2(NUM);
  localparam int PPN_W = PALEN - 12;

  logic [NPORT-1:0]        s_req;
  logic [NPORT*19-1:0]     s_vppn;
  logic [NPORT-1:0]        s_va_bit12;
  logic [NPORT*ASID_W-1:0] s_asid;
  logic [NPORT-1:0]        s_rvalid;
  logic [NPORT-1:0]        s_found;
  logic [NPORT*IW-1:0]     s_index;
  logic [NPORT*PPN_W-1:0]  s_ppn;
  logic [NPORT*6-1:0]      s_ps;
  logic [NPORT*2-1:0]      s_plv;
  logic [NPORT*2-1:0]      s_mat;
  logic [NPORT-1:0]        s_d;
  logic [NPORT-1:0]        s_v;
  logic [NPORT-1:0]        s_multi;

  modport master (
    output s_req, s_vppn, s_va_bit12, s_asid,
    input  s_rvalid, s_found, s_index, s_ppn,
    input  s_ps, s_plv, s_mat, s_d, s_v, s_multi
  );

  modport slave (
    input  s_req, s_vppn, s_va_bit12, s_asid,
    output s_rvalid, s_found, s_index, s_ppn,
    output s_ps, s_plv, s_mat, s_d, s_v, s_multi
  );
endinterface

// File: rtl/tlb_mp.sv
// Fully associative multi-port TLB with round-robin fill and INVTLB.
// Define TLB_MULTIHIT_EN to register a per-port multi-hit flag.
module tlb_mp #(
  parameter int NUM    = 16,
  parameter int NPORT  = 2,
  parameter int ASID_W = 10,
  parameter int PALEN  = 32,
  parameter int IW     = $clog2(NUM),
  parameter int PPN_W  = PALEN - 12,
  parameter int EW     = 27 + ASID_W + 2*(PPN_W+6)
) (
  input  logic              clk,
  input  logic              reset,
  tlb_mp_if.slave           s,
  input  logic              we,
  input  logic              w_fill,
  input  logic [IW-1:0]     w_index,
  input  logic [EW-1:0]     w_entry,
  output logic [IW-1:0]     fill_index,
  input  logic [IW-1:0]     r_index,
  output logic [EW-1:0]     r_entry,
  input  logic              inv_valid,
  input  logic [4:0]        inv_op,
  input  logic [ASID_W-1:0] inv_asid,
  input  logic [18:0]       inv_vppn,
  output logic              inv_ine
);
  localparam int H = PPN_W + 6;

  logic [EW-2:0]     mem [NUM];
  logic [NUM-1:0]    e_q;
  logic [18:0]       f_vppn [NUM];
  logic [5:0]        f_ps   [NUM];
  logic [ASID_W-1:0] f_asid [NUM];
  logic [NUM-1:0]    f_g;
  logic [H-1:0]      f_h0   [NUM];
  logic [H-1:0]      f_h1   [NUM];
  logic [NUM-1:0]    inv_va;
  logic [NUM-1:0]    inv_as;
  logic [NUM-1:0]    kill;
  logic [IW-1:0]     tgt;

  for (genvar k = 0; k < NUM; k++) begin : g_ent
    assign f_vppn[k] = mem[k][EW-2 -: 19];
    assign f_ps[k]   = mem[k][EW-21 -: 6];
    assign f_asid[k] = mem[k][EW-27 -: ASID_W];
    assign f_g[k]    = mem[k][2*H];
    assign f_h0[k]   = mem[k][2*H-1 -: H];
    assign f_h1[k]   = mem[k][H-1:0];
    assign inv_as[k] = f_asid[k] == inv_asid;
    assign inv_va[k] = (f_vppn[k][18:9] == inv_vppn[18:9])
                     & ((f_ps[k] == 6'd21)
                     | (f_vppn[k][8:0] == inv_vppn[8:0]));
  end

  assign tgt     = w_fill ? fill_index : w_index;
  assign r_entry = {e_q[r_index], mem[r_index]};
  assign inv_ine = inv_valid & (inv_op > 5'd6);

  always_comb begin
    kill = '0;
    for (int k = 0; k < NUM; k++) begin
      case (inv_op)
        5'd0, 5'd1: kill[k] = 1'b1;
        5'd2:       kill[k] = f_g[k];
        5'd3:       kill[k] = ~f_g[k];
        5'd4:       kill[k] = ~f_g[k] & inv_as[k];
        5'd5:       kill[k] = ~f_g[k] & inv_as[k] & inv_va[k];
        5'd6:       kill[k] = (f_g[k] | inv_as[k]) & inv_va[k];
        default:    kill[k] = 1'b0;
      endcase
    end
    kill = kill & {NUM{inv_valid}};
  end

  // The written slot takes w_entry.e even when an invalidate hits it.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
    end else begin
      for (int k = 0; k < NUM; k++) begin
        if (we && tgt == k[IW-1:0])
          e_q[k] <= w_entry[EW-1];
        else if (kill[k])
          e_q[k] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && we)
      mem[tgt] <= w_entry[EW-2:0];
  end

  always_ff @(posedge clk) begin
    if (reset)
      fill_index <= '0;
    else if (we && w_fill)
      fill_index <= fill_index + 1'b1;
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [18:0]       vp;
    logic              b12;
    logic [ASID_W-1:0] as;
    logic [NUM-1:0]    hit;
    logic [IW-1:0]     hidx;
    logic              found;
    logic              odd;
    logic [H-1:0]      half;
    logic              rv_q;
    logic              fd_q;
    logic [IW-1:0]     idx_q;
    logic [PPN_W-1:0]  ppn_q;
    logic [5:0]        ps_q;
    logic [1:0]        plv_q;
    logic [1:0]        mat_q;
    logic              d_q;
    logic              v_q;

    assign vp  = s.s_vppn[p*19 +: 19];
    assign b12 = s.s_va_bit12[p];
    assign as  = s.s_asid[p*ASID_W +: ASID_W];

    always_comb begin
      hit = '0;
      for (int i = 0; i < NUM; i++)
        hit[i] = e_q[i]
               & (f_g[i] | (f_asid[i] == as))
               & (f_vppn[i][18:9] == vp[18:9])
               & ((f_ps[i] == 6'd21)
               | (f_vppn[i][8:0] == vp[8:0]));
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
      hidx = '0;
      for (int i = NUM-1; i >= 0; i--)
        if (hit[i]) hidx = i[IW-1:0];
    end

    assign found = |hit;
    assign odd   = (f_ps[hidx] == 6'd21) ? vp[8] : b12;
    assign half  = odd ? f_h1[hidx] : f_h0[hidx];

    always_ff @(posedge clk) begin
      if (reset) begin
        rv_q  <= 1'b0;
        fd_q  <= 1'b0;
        idx_q <= '0;
        ppn_q <= '0;
        ps_q  <= '0;
        plv_q <= '0;
        mat_q <= '0;
        d_q   <= 1'b0;
        v_q   <= 1'b0;
      end else begin
        rv_q <= s.s_req[p];
        if (s.s_req[p]) begin
          fd_q  <= found;
          idx_q <= found ? hidx : '0;
          ppn_q <= found ? half[H-1 -: PPN_W] : '0;
          ps_q  <= found ? f_ps[hidx] : '0;
          plv_q <= found ? half[5:4] : '0;
          mat_q <= found ? half[3:2] : '0;
          d_q   <= found & half[1];
          v_q   <= found & half[0];
        end
      end
    end

    assign s.s_rvalid[p]                = rv_q;
    assign s.s_found[p]                 = fd_q;
    assign s.s_index[p*IW +: IW]        = idx_q;
    assign s.s_ppn[p*PPN_W +: PPN_W]    = ppn_q;
    assign s.s_ps[p*6 +: 6]             = ps_q;
    assign s.s_plv[p*2 +: 2]            = plv_q;
    assign s.s_mat[p*2 +: 2]            = mat_q;
    assign s.s_d[p]                     = d_q;
    assign s.s_v[p]                     = v_q;

`ifdef TLB_MULTIHIT_EN
    logic seen;
    logic multi;
    logic mu_q;

    always_comb begin
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < NUM; i++) begin
        if (hit[i]) begin
          multi = multi | seen;
          seen  = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset)
        mu_q <= 1'b0;
      else if (s.s_req[p])
        mu_q <= multi;
    end

    assign s.s_multi[p] = mu_q;
`else
    assign s.s_multi[p] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_tlb_mp.sv
// Directed bench for tlb_mp: lookups, TLBWR/TLBFILL, INVTLB, reset.
module tb_tlb_mp;
  localparam int NUM = 16, NPORT = 2, ASID_W = 10, PALEN = 32;
  localparam int IW = 4, PPN_W = 20, EW = 89;
`ifdef TLB_MULTIHIT_EN
  localparam logic MH = 1'b1;
`else
  localparam logic MH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_mp_if #(.NUM(NUM), .NPORT(NPORT), .ASID_W(ASID_W),
              .PALEN(PALEN)) ifc ();

  logic              we, w_fill, inv_valid, inv_ine;
  logic [IW-1:0]     w_index, fill_index, r_index;
  logic [EW-1:0]     w_entry, r_entry;
  logic [4:0]        inv_op;
  logic [ASID_W-1:0] inv_asid;
  logic [18:0]       inv_vppn;

  tlb_mp #(.NUM(NUM), .NPORT(NPORT), .ASID_W(ASID_W),
           .PALEN(PALEN)) dut (
    .clk(clk), .reset(reset), .s(ifc),
    .we(we), .w_fill(w_fill), .w_index(w_index),
    .w_entry(w_entry), .fill_index(fill_index),
    .r_index(r_index), .r_entry(r_entry),
    .inv_valid(inv_valid), .inv_op(inv_op),
    .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_ine(inv_ine)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(
    logic e, logic [18:0] vp, logic [5:0] ps, logic [9:0] as,
    logic g, logic [19:0] p0, logic [1:0] l0, logic [1:0] m0,
    logic d0, logic v0, logic [19:0] p1, logic [1:0] l1,
    logic [1:0] m1, logic d1, logic v1);
    return {e, vp, ps, as, g, p0, l0, m0, d0, v0,
            p1, l1, m1, d1, v1};
  endfunction

  function automatic logic fnd(int p);
    return ifc.s_found[p];
  endfunction
  function automatic logic [IW-1:0] idx(int p);
    return ifc.s_index[p*IW +: IW];
  endfunction
  function automatic logic [PPN_W-1:0] ppn(int p);
    return ifc.s_ppn[p*PPN_W +: PPN_W];
  endfunction

  task automatic wr(input logic f, input logic [IW-1:0] i,
                    input logic [EW-1:0] ent);
    @(negedge clk);
    we = 1'b1; w_fill = f; w_index = i; w_entry = ent;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic lk(input int p, input logic [18:0] vp,
                    input logic b, input logic [9:0] as);
    ifc.s_req[p] = 1'b1;
    ifc.s_vppn[p*19 +: 19] = vp;
    ifc.s_va_bit12[p] = b;
    ifc.s_asid[p*ASID_W +: ASID_W] = as;
  endtask

  task automatic step();
    @(negedge clk);
    ifc.s_req = '0;
  endtask

  task automatic get_e(output logic [NUM-1:0] ev);
    for (int i = 0; i < NUM; i++) begin
      r_index = i[IW-1:0];
      #1;
      ev[i] = r_entry[EW-1];
    end
  endtask

  logic [EW-1:0]  e3, e1, e4, e2, ef;
  logic [NUM-1:0] ev;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; we = 1'b0; w_fill = 1'b0; w_index = '0;
    w_entry = '0; r_index = '0; inv_valid = 1'b0; inv_op = '0;
    inv_asid = '0; inv_vppn = '0;
    ifc.s_req = '0; ifc.s_vppn = '0; ifc.s_va_bit12 = '0;
    ifc.s_asid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_fill", fill_index, 0);
    chk("rst_rvalid", ifc.s_rvalid, 0);
    chk("rst_found", ifc.s_found, 0);
    r_index = 3; #1;
    chk("rst_e3", r_entry[EW-1], 0);

    @(negedge clk);
    lk(0, 19'h12345, 1'b1, 10'd5);
    lk(1, 19'h00000, 1'b0, 10'd0);
    chk("req_cycle_rvalid", ifc.s_rvalid, 0);
    step();
    chk("empty_rvalid", ifc.s_rvalid, 2'b11);
    chk("empty_found", ifc.s_found, 0);
    chk("empty_ppn", ifc.s_ppn, 0);

    e3 = mk(1, 19'h12345, 12, 5, 0, 20'hA000, 1, 1, 1, 1,
            20'hB000, 2, 0, 0, 1);
    wr(0, 3, e3);
    chk("wr_fill_hold", fill_index, 0);
    r_index = 3; #1;
    chk("rd_e3", r_entry, e3);

    @(negedge clk);
    lk(0, 19'h12345, 1'b1, 10'd5);
    lk(1, 19'h12345, 1'b1, 10'd6);
    step();
    chk("odd_found", fnd(0), 1);
    chk("odd_index", idx(0), 3);
    chk("odd_ppn", ppn(0), 20'hB000);
    chk("odd_plv", ifc.s_plv[1:0], 2);
    chk("odd_ps", ifc.s_ps[5:0], 12);
    chk("odd_dv", {ifc.s_d[0], ifc.s_v[0]}, 2'b01);
    chk("asid_miss", fnd(1), 0);
    chk("asid_miss_ppn", ppn(1), 0);

    @(negedge clk);
    lk(0, 19'h12345, 1'b0, 10'd5);
    step();
    chk("even_ppn", ppn(0), 20'hA000);
    chk("even_d", ifc.s_d[0], 1);
    chk("even_mat", ifc.s_mat[1:0], 1);
    step();
    chk("hold_rvalid", ifc.s_rvalid, 0);
    chk("hold_ppn", ppn(0), 20'hA000);

    e1 = mk(1, 19'h12200, 21, 10'h3FF, 1, 20'h40000, 0, 0, 0, 1,
            20'h40200, 3, 2, 1, 1);
    e4 = mk(1, 19'h122FF, 12, 7, 0, 20'h1111, 0, 0, 0, 1,
            20'h2222, 0, 0, 0, 1);
    wr(0, 1, e1);
    wr(0, 4, e4);
    @(negedge clk);
    lk(0, 19'h122FF, 1'b1, 10'd7);
    lk(1, 19'h12300, 1'b0, 10'd9);
    step();
    chk("big_index", idx(0), 1);
    chk("big_even_ppn", ppn(0), 20'h40000);
    chk("big_ps", ifc.s_ps[5:0], 21);
    chk("big_multi", ifc.s_multi[0], MH);
    chk("big_odd_found", fnd(1), 1);
    chk("big_odd_ppn", ppn(1), 20'h40200);
    chk("big_odd_plv", ifc.s_plv[3:2], 3);
    chk("single_multi", ifc.s_multi[1], 0);

    for (int i = 0; i <= NUM; i++) begin
      chk("fill_ptr", fill_index, i % NUM);
      ef = mk(1, 19'h50000 + 19'(i), 12, 1, 0, 20'h100 + 20'(i),
              0, 0, 0, 1, 20'h0, 0, 0, 0, 0);
      wr(1, 9, ef);
    end
    chk("fill_wrap", fill_index, 1);
    r_index = 0; #1;
    chk("fill_over0", r_entry, ef);
    r_index = 1; #1;
    chk("fill_e1_vppn", r_entry[87:69], 19'h50001);

    @(negedge clk);
    lk(0, 19'h50010, 1'b0, 10'd1);
    step();
    chk("fill_lk_idx", idx(0), 0);
    chk("fill_lk_ppn", ppn(0), 20'h110);

    wr(0, 5, mk(1, 19'h60000, 12, 5, 1, 20'h600, 0, 0, 0, 1,
                20'h601, 0, 0, 0, 1));
    wr(0, 6, mk(1, 19'h60001, 12, 5, 0, 20'h610, 0, 0, 0, 1,
                20'h611, 0, 0, 0, 1));
    wr(0, 7, mk(1, 19'h60002, 12, 5, 0, 20'h620, 0, 0, 0, 1,
                20'h621, 0, 0, 0, 1));

    @(negedge clk);
    inv_valid = 1'b1; inv_op = 7; inv_asid = 5; #1;
    chk("ine_op7", inv_ine, 1);
    @(negedge clk);
    inv_valid = 1'b0; #1;
    chk("ine_idle", inv_ine, 0);
    get_e(ev);
    chk("op7_keep", ev, 16'hFFFF);

    @(negedge clk);
    inv_valid = 1'b1; inv_op = 4; inv_asid = 5; #1;
    chk("ine_op4", inv_ine, 0);
    @(negedge clk);
    inv_valid = 1'b0;
    get_e(ev);
    chk("op4_g0_only", ev, 16'hFF3F);

    @(negedge clk);
    inv_valid = 1'b1; inv_op = 5; inv_asid = 1;
    inv_vppn = 19'h50003;
    @(negedge clk);
    inv_valid = 1'b0;
    get_e(ev);
    chk("op5_va", ev, 16'hFF37);

    @(negedge clk);
    inv_valid = 1'b1; inv_op = 2;
    @(negedge clk);
    inv_valid = 1'b0;
    get_e(ev);
    chk("op2_global", ev, 16'hFF17);

    e2 = mk(1, 19'h70000, 12, 3, 0, 20'h777, 0, 0, 0, 1,
            20'h778, 0, 0, 0, 1);
    @(negedge clk);
    we = 1'b1; w_fill = 1'b0; w_index = 2; w_entry = e2;
    inv_valid = 1'b1; inv_op = 0;
    lk(0, 19'h50008, 1'b0, 10'd1);
    lk(1, 19'h70000, 1'b0, 10'd3);
    @(negedge clk);
    we = 1'b0; inv_valid = 1'b0; ifc.s_req = '0;
    chk("pre_upd_hit", {fnd(0), idx(0)}, {1'b1, 4'd8});
    chk("pre_upd_ppn", ppn(0), 20'h108);
    chk("pre_upd_miss", fnd(1), 0);
    chk("wr_inv_fill", fill_index, 1);
    get_e(ev);
    chk("wr_inv_e", ev, 16'h0004);

    @(negedge clk);
    lk(0, 19'h70000, 1'b0, 10'd3);
    lk(1, 19'h50008, 1'b0, 10'd1);
    step();
    chk("post_hit", {fnd(0), idx(0)}, {1'b1, 4'd2});
    chk("post_ppn", ppn(0), 20'h777);
    chk("post_miss", fnd(1), 0);

    @(negedge clk);
    reset = 1'b1; we = 1'b1; w_fill = 1'b1; w_index = 0;
    w_entry = e2;
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    chk("rst2_fill", fill_index, 0);
    chk("rst2_found", ifc.s_found, 0);
    get_e(ev);
    chk("rst2_e", ev, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
